// File: rtl/argmax_classifier.sv
// ---------------------------------------------------------------------------
// argmax_classifier
//
// Streams NUM_CLASSES signed scores per frame (class index = arrival order)
// and reports the index of the largest score, the score itself, the margin
// between the winner and the runner-up, and a low-confidence flag when that
// margin does not exceed MARGIN_TH. The block alternates between collecting
// a frame and holding its result until the consumer takes it.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   valid_in   : a score is present on data_in
//   data_in    : signed score (DATA_W bits)
//   in_ready   : block accepts a score this cycle (COLLECT state)
//   flush      : synchronous abort of the current frame / held result
//   out_ready  : consumer accepts the result
//   valid_out  : result valid (HOLD state)
//   decision   : winning class index (IDX_W bits)
//   max_score  : signed winning score (DATA_W bits)
//   margin     : unsigned winner minus runner-up (DATA_W+1 bits)
//   low_conf   : margin <= MARGIN_TH
// ---------------------------------------------------------------------------
module argmax_classifier #(
    parameter int              NUM_CLASSES = 2,
    parameter int              DATA_W      = 12,
    parameter int              IDX_W       = 6,
    parameter logic [DATA_W:0] MARGIN_TH   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              valid_out,
    output logic [IDX_W-1:0]  decision,
    output logic [DATA_W-1:0] max_score,
    output logic [DATA_W:0]   margin,
    output logic              low_conf
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] best_q, best_d;
    logic signed [DATA_W-1:0] second_q, second_d;
    logic [IDX_W-1:0]         bestIdx_q, bestIdx_d;
    logic [IDX_W-1:0]         decision_q, decision_d;
    logic [DATA_W-1:0]        maxScore_q, maxScore_d;
    logic [DATA_W:0]          margin_q, margin_d;
    logic                     lowConf_q, lowConf_d;

    logic signed [DATA_W-1:0] score;
    logic signed [DATA_W-1:0] candBest;
    logic signed [DATA_W-1:0] candSecond;
    logic [IDX_W-1:0]         candIdx;
    logic [DATA_W:0]          candMargin;
    logic                     accept;
    logic                     isLast;

    assign score  = $signed(data_in);
    assign accept = valid_in && (state_q == COLLECT);
    assign isLast = (cnt_q == LAST_IDX);

    // Tracking state as it would look after absorbing the incoming score.
    // A strict greater-than keeps ties on the lowest index; an equal score
    // lands in the runner-up slot instead, giving a zero margin. The margin
    // is formed on sign-extended operands so the full signed range fits.
    always_comb begin
        candBest   = best_q;
        candSecond = second_q;
        candIdx    = bestIdx_q;
        if (cnt_q == '0) begin
            candBest   = score;
            candIdx    = '0;
            candSecond = MOST_NEG;
        end else if (score > best_q) begin
            candSecond = best_q;
            candBest   = score;
            candIdx    = cnt_q;
        end else if (score > second_q) begin
            candSecond = score;
        end
        candMargin = {candBest[DATA_W-1], candBest} - {candSecond[DATA_W-1], candSecond};
    end

    // Next-state logic: collect scores until the last class, latch the result
    // into the output registers on that same edge, then hold until the
    // consumer handshakes. Flush is applied last so it wins over everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        second_d   = second_q;
        bestIdx_d  = bestIdx_q;
        decision_d = decision_q;
        maxScore_d = maxScore_q;
        margin_d   = margin_q;
        lowConf_d  = lowConf_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    best_d    = candBest;
                    second_d  = candSecond;
                    bestIdx_d = candIdx;
                    if (isLast) begin
                        cnt_d      = '0;
                        state_d    = HOLD;
                        decision_d = candIdx;
                        maxScore_d = candBest;
                        margin_d   = candMargin;
                        lowConf_d  = (candMargin <= MARGIN_TH);
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        if (flush) begin
            state_d    = COLLECT;
            cnt_d      = '0;
            best_d     = '0;
            second_d   = MOST_NEG;
            bestIdx_d  = '0;
            decision_d = '0;
            maxScore_d = '0;
            margin_d   = '0;
            lowConf_d  = 1'b0;
        end
    end

    // State and result registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            best_q     <= '0;
            second_q   <= MOST_NEG;
            bestIdx_q  <= '0;
            decision_q <= '0;
            maxScore_q <= '0;
            margin_q   <= '0;
            lowConf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            second_q   <= second_d;
            bestIdx_q  <= bestIdx_d;
            decision_q <= decision_d;
            maxScore_q <= maxScore_d;
            margin_q   <= margin_d;
            lowConf_q  <= lowConf_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign valid_out = (state_q == HOLD);
    assign decision  = decision_q;
    assign max_score = maxScore_q;
    assign margin    = margin_q;
    assign low_conf  = lowConf_q;

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 2, meaning scores per frame; legal range 2..64.
REQ-002 SHALL have parameter DATA_W, default 12, meaning signed score width.
REQ-003 SHALL have parameter IDX_W, default 6, meaning decision width; must satisfy 2^IDX_W >= NUM_CLASSES.
REQ-004 SHALL have parameter MARGIN_TH, default 0, meaning unsigned low-confidence threshold, DATA_W+1 bits.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port valid_in, input, 1, score present on data_in.
REQ-008 SHALL have port data_in, input, DATA_W, signed score; class index is its arrival order within the frame.
REQ-009 SHALL have port in_ready, output, 1, block accepts a score this cycle.
REQ-010 SHALL have port flush, input, 1, synchronous abort of the current frame.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port valid_out, output, 1, result valid.
REQ-013 SHALL have port decision, output, IDX_W, winning class index.
REQ-014 SHALL have port max_score, output, DATA_W, signed winning score.
REQ-015 SHALL have port margin, output, DATA_W+1, unsigned winner minus runner-up.
REQ-016 SHALL have port low_conf, output, 1, high when margin <= MARGIN_TH.

Function
REQ-017 SHALL implement two states: COLLECT (in_ready=1, valid_out=0) and HOLD (in_ready=0, valid_out=1).
REQ-018 SHALL accept a score only when valid_in && in_ready; valid_in in HOLD is ignored, not queued.
REQ-019 SHALL keep a class counter 0..NUM_CLASSES-1, incremented per accepted score, cleared to 0 after the last score.
REQ-020 SHALL, on the first score of a frame, load best=data_in, best_idx=0, second=most-negative DATA_W value.
REQ-021 SHALL, on later score k: if data_in > best then second=best, best=data_in, best_idx=k; else if data_in > second then second=data_in; else no change.
REQ-022 SHALL resolve ties to the lowest index (equal score never replaces best; it sets second, giving margin 0).
REQ-023 SHALL compute margin = best - second in DATA_W+1 bits without overflow.
REQ-024 SHALL enter HOLD on the cycle after the last score is accepted: valid_out high exactly 1 cycle after final acceptance, with decision/max_score/margin/low_conf valid then.
REQ-025 SHALL hold all outputs stable in HOLD while out_ready is 0, for any duration.
REQ-026 SHALL return to COLLECT on the cycle after valid_out && out_ready; in_ready high on that next cycle.
REQ-027 SHALL, on flush, clear counter and tracking, go to COLLECT, deassert valid_out next cycle; flush overrides valid_in and out_ready in the same cycle.
REQ-028 SHALL support back-to-back frames with one bubble cycle: minimum period NUM_CLASSES+1 cycles when out_ready is tied high.
REQ-029 SHALL give results bit-exact with NUM_CLASSES=2: decision=1 iff score1 > score0.

Reset
REQ-030 SHALL on rst_n low asynchronously force COLLECT, counter 0, valid_out=0, decision=0, max_score=0, margin=0, low_conf=0, in_ready=1 upon release.
REQ-031 SHALL discard any partial frame on reset mid-frame; first score after release is class 0.

Verification
REQ-032 SHALL pass: N=2, scores -5,+7, out_ready=1 -> valid_out 1 cycle after 2nd score, decision=1, max_score=7, margin=12.
REQ-033 SHALL pass: N=4, scores 3,9,9,-2 -> decision=1, max_score=9, margin=0, low_conf=1 (MARGIN_TH=0).
REQ-034 SHALL pass: N=4, scores 10,2,4,1, out_ready low 5 cycles -> outputs stable, in_ready=0, extra valid_in ignored; after out_ready, decision=0, margin=6.
REQ-035 SHALL pass: N=4, DATA_W=12, scores -2048,2047,-2048,0 -> decision=1, max_score=2047, margin=2047; all -2048 -> decision=0, margin=0.
REQ-036 SHALL pass: flush after 2 of 4 scores, then 1,2,3,4 -> decision=3, margin=1; repeat with rst_n pulse instead of flush -> same result.
REQ-037 SHALL pass: 3 back-to-back N=3 frames, out_ready=1 -> valid_out every 4 cycles with correct per-frame decisions.
